// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchronizer, 16x oversample tick generator and
// a start/data/stop FSM that samples mid-bit and reports data plus framing error.
module uart_rx #(
    parameter real CLOCK     = 50E6,
    parameter int  BAUD_RATE = 19200,
    parameter int  N_BITS    = 8,
    parameter int  SB_TICK   = 16
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_rx,
    output logic [N_BITS-1:0] o_rx_data,
    output logic              o_rx_done_tick,
    output logic              o_frame_error
);

    localparam int DIV_RAW = $rtoi(CLOCK / (BAUD_RATE * 16.0));
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int NW      = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic [1:0]        sync_r;
    logic              rx_s;
    logic [CW-1:0]     baud_cnt_r;
    logic              baud_tick_s;

    state_t            state_r, state_nx_s;
    logic [3:0]        s_r, s_nx_s;
    logic [NW-1:0]     n_r, n_nx_s;
    logic [N_BITS-1:0] shift_r, shift_nx_s;
    logic [N_BITS-1:0] data_r, data_nx_s;
    logic              ferr_r, ferr_nx_s;
    logic              done_r, done_nx_s;

    // Two-flop synchronizer for the asynchronous line; resets to the idle level.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], i_rx};
        end
    end

    assign rx_s = sync_r[1];

    // Free-running oversample divider; the tick fires on the terminal count.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            baud_cnt_r <= '0;
        end else if (baud_tick_s) begin
            baud_cnt_r <= '0;
        end else begin
            baud_cnt_r <= baud_cnt_r + CW'(1);
        end
    end

    assign baud_tick_s = (baud_cnt_r == CW'(DIV - 1));

    // FSM state, counters, shift register and registered outputs.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_r <= ST_IDLE;
            s_r     <= 4'd0;
            n_r     <= '0;
            shift_r <= '0;
            data_r  <= '0;
            ferr_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            s_r     <= s_nx_s;
            n_r     <= n_nx_s;
            shift_r <= shift_nx_s;
            data_r  <= data_nx_s;
            ferr_r  <= ferr_nx_s;
            done_r  <= done_nx_s;
        end
    end

    // Next-state logic; start detection in IDLE is not gated by the tick.
    always_comb begin
        state_nx_s = state_r;
        s_nx_s     = s_r;
        n_nx_s     = n_r;
        shift_nx_s = shift_r;
        data_nx_s  = data_r;
        ferr_nx_s  = ferr_r;
        done_nx_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_nx_s = ST_START;
                    s_nx_s     = 4'd0;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end

            ST_START: begin
                if (baud_tick_s) begin
                    if (s_r == 4'd7) begin
                        if (!rx_s) begin
                            state_nx_s = ST_DATA;
                            s_nx_s     = 4'd0;
                            n_nx_s     = '0;
                        end else begin
                            state_nx_s = ST_IDLE;
                        end
                    end else begin
                        s_nx_s = s_r + 4'd1;
                    end
                end else begin
                    s_nx_s = s_r;
                end
            end

            ST_DATA: begin
                if (baud_tick_s) begin
                    if (s_r == 4'd15) begin
                        s_nx_s                 = 4'd0;
                        shift_nx_s             = shift_r >> 1;
                        shift_nx_s[N_BITS-1]   = rx_s;
                        if (n_r == NW'(N_BITS - 1)) begin
                            state_nx_s = ST_STOP;
                        end else begin
                            n_nx_s = n_r + NW'(1);
                        end
                    end else begin
                        s_nx_s = s_r + 4'd1;
                    end
                end else begin
                    s_nx_s = s_r;
                end
            end

            ST_STOP: begin
                if (baud_tick_s) begin
                    if (s_r == 4'(SB_TICK - 1)) begin
                        data_nx_s  = shift_r;
                        ferr_nx_s  = ~rx_s;
                        done_nx_s  = 1'b1;
                        state_nx_s = ST_IDLE;
                    end else begin
                        s_nx_s = s_r + 4'd1;
                    end
                end else begin
                    s_nx_s = s_r;
                end
            end

            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    assign o_rx_data      = data_r;
    assign o_rx_done_tick = done_r;
    assign o_frame_error  = ferr_r;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at CLOCK=3200, BAUD_RATE=100 (32 clocks per bit).
module tb_uart_rx;

    localparam int BIT_CYC = 32;

    logic       i_clock = 1'b0;
    logic       i_reset;
    logic       i_rx;
    logic [7:0] o_rx_data;
    logic       o_rx_done_tick;
    logic       o_frame_error;

    int         checks = 0;
    int         passes = 0;
    int         pulses = 0;
    logic [8:0] sb_q[$];
    logic       prev_done = 1'b0;

    uart_rx #(
        .CLOCK     (3200),
        .BAUD_RATE (100),
        .N_BITS    (8),
        .SB_TICK   (16)
    ) dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_rx           (i_rx),
        .o_rx_data      (o_rx_data),
        .o_rx_done_tick (o_rx_done_tick),
        .o_frame_error  (o_frame_error)
    );

    always #5 i_clock = ~i_clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected frame.
    always @(negedge i_clock) begin
        logic [8:0] exp;
        if (i_reset) begin
            prev_done = 1'b0;
        end else begin
            if (o_rx_done_tick) begin
                pulses++;
                check("done_not_consecutive", {31'd0, prev_done}, 32'd0);
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp = sb_q.pop_front();
                    check("rx_data", {24'd0, o_rx_data}, {24'd0, exp[7:0]});
                    check("frame_error", {31'd0, o_frame_error}, {31'd0, exp[8]});
                end
            end
            prev_done = o_rx_done_tick;
        end
    end

    task automatic drive_bit(input logic b, input int cycles);
        i_rx = b;
        repeat (cycles) @(posedge i_clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_ok);
        drive_bit(1'b0, BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            drive_bit(d[i], BIT_CYC);
        end
        if (stop_ok) begin
            drive_bit(1'b1, BIT_CYC);
        end else begin
            // Low across the mid-bit sample, released early so the tail is not a new start.
            drive_bit(1'b0, 24);
            drive_bit(1'b1, 8);
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) begin
            @(posedge i_clock);
        end
        #1;
        check(name, sb_q.size(), 32'd0);
    endtask

    initial begin
        i_reset = 1'b1;
        i_rx    = 1'b1;
        repeat (3) @(posedge i_clock);
        #1;
        check("reset_rx_data", {24'd0, o_rx_data}, 32'd0);
        check("reset_done", {31'd0, o_rx_done_tick}, 32'd0);
        check("reset_frame_error", {31'd0, o_frame_error}, 32'd0);
        i_reset = 1'b0;
        drive_bit(1'b1, 40);

        // Valid frame 0xA5.
        sb_q.push_back({1'b0, 8'hA5});
        send_frame(8'hA5, 1'b1);
        wait_drain("drain_a5");
        drive_bit(1'b1, 40);

        // False start: 8 cycles low is shorter than the half-bit check.
        drive_bit(1'b0, 8);
        drive_bit(1'b1, 80);
        check("false_start_hold", {24'd0, o_rx_data}, 32'h0000_00A5);
        check("false_start_pulses", pulses, 32'd1);

        // Framing error on 0x3C, then a valid 0x81.
        sb_q.push_back({1'b1, 8'h3C});
        send_frame(8'h3C, 1'b0);
        wait_drain("drain_3c");
        drive_bit(1'b1, 40);
        check("ferr_hold", {31'd0, o_frame_error}, 32'd1);
        sb_q.push_back({1'b0, 8'h81});
        send_frame(8'h81, 1'b1);
        wait_drain("drain_81");
        drive_bit(1'b1, 40);

        // Reset during bit 4 of 0xFF abandons the frame.
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (5 * BIT_CYC + 16) @(posedge i_clock);
                #1;
                i_reset = 1'b1;
                repeat (3) @(posedge i_clock);
                #1;
                check("midreset_rx_data", {24'd0, o_rx_data}, 32'd0);
                check("midreset_done", {31'd0, o_rx_done_tick}, 32'd0);
                check("midreset_frame_error", {31'd0, o_frame_error}, 32'd0);
                i_reset = 1'b0;
            end
        join
        drive_bit(1'b1, 40);
        check("midreset_no_pulse", pulses, 32'd3);
        sb_q.push_back({1'b0, 8'h5A});
        send_frame(8'h5A, 1'b1);
        wait_drain("drain_5a");
        drive_bit(1'b1, 40);
        check("hold_5a", {24'd0, o_rx_data}, 32'h0000_005A);

        // Back-to-back frames with no idle gap.
        sb_q.push_back({1'b0, 8'h00});
        sb_q.push_back({1'b0, 8'hFF});
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_drain("drain_b2b");
        drive_bit(1'b1, 40);
        check("total_pulses", pulses, 32'd6);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
